// File: rtl/vpu_test_sequencer_if.sv
// Request/result channel between the VPU self-test sequencer (master) and the VPU (slave).
interface vpu_test_sequencer_if #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DATA_W  = 64
);
    logic               vpu_req_valid;
    logic               vpu_req_ready;
    logic [INSTR_W-1:0] vpu_instr;
    logic               vpu_res_valid;
    logic [DATA_W-1:0]  vpu_res_data;

    modport master (
        output vpu_req_valid,
        output vpu_instr,
        input  vpu_req_ready,
        input  vpu_res_valid,
        input  vpu_res_data
    );

    modport slave (
        input  vpu_req_valid,
        input  vpu_instr,
        output vpu_req_ready,
        output vpu_res_valid,
        output vpu_res_data
    );
endinterface

// File: rtl/vpu_test_sequencer.sv
// VPU self-test sequencer: fetches vectors from ROM, issues them, checks results, drives LEDs.
// Optional continuous soak looping is enabled by defining VPU_SEQ_SOAK_EN.
module vpu_test_sequencer #(
    parameter int unsigned NUM_TESTS   = 16,
    parameter int unsigned INSTR_W     = 32,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned START_DELAY = 64,
    localparam int unsigned IDX_W      = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
    input  logic               clk_100mhz,
    input  logic               rst,
    output logic [IDX_W-1:0]   rom_addr,
    input  logic [INSTR_W-1:0] rom_instr,
    input  logic [DATA_W-1:0]  rom_expected,
    vpu_test_sequencer_if.master vpu,
    output logic [IDX_W-1:0]   fail_index,
    output logic               fail_timeout,
    output logic [3:0]         led
`ifdef VPU_SEQ_SOAK_EN
    ,
    output logic [15:0]        pass_loops
`endif
);
    localparam int unsigned DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StIssue, StWait, StPass, StFail} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0]  exp_q, exp_d;
    logic [IDX_W-1:0]   fidx_q, fidx_d;
    logic               ftmo_q, ftmo_d;
    logic [3:0]         led_q, led_d;
`ifdef VPU_SEQ_SOAK_EN
    logic [15:0]        loops_q, loops_d;
    logic               tgl_q, tgl_d;
`endif

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            dly_q   <= '0;
            tmo_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            exp_q   <= '0;
            fidx_q  <= '0;
            ftmo_q  <= 1'b0;
            led_q   <= 4'b0000;
`ifdef VPU_SEQ_SOAK_EN
            loops_q <= '0;
            tgl_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            exp_q   <= exp_d;
            fidx_q  <= fidx_d;
            ftmo_q  <= ftmo_d;
            led_q   <= led_d;
`ifdef VPU_SEQ_SOAK_EN
            loops_q <= loops_d;
            tgl_q   <= tgl_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        tmo_d   = tmo_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        instr_d = instr_q;
        exp_d   = exp_q;
        fidx_d  = fidx_q;
        ftmo_d  = ftmo_q;
`ifdef VPU_SEQ_SOAK_EN
        loops_d = loops_q;
        tgl_d   = tgl_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (dly_q == DLY_W'(START_DELAY - 1)) begin
                    state_d = StFetch;
                    idx_d   = '0;
                    addr_d  = '0;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                instr_d = rom_instr;
                exp_d   = rom_expected;
                valid_d = 1'b1;
                state_d = StIssue;
            end
            StIssue: begin
                if (vpu.vpu_req_ready) begin
                    valid_d = 1'b0;
                    tmo_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // A result arriving on the final timeout cycle still wins.
                if (vpu.vpu_res_valid) begin
                    if (vpu.vpu_res_data != exp_q) begin
                        state_d = StFail;
                        fidx_d  = idx_q;
                    end else if (idx_q == IDX_W'(NUM_TESTS - 1)) begin
`ifdef VPU_SEQ_SOAK_EN
                        state_d = StFetch;
                        idx_d   = '0;
                        addr_d  = '0;
                        tgl_d   = ~tgl_q;
                        if (loops_q != 16'hffff) loops_d = loops_q + 16'd1;
`else
                        state_d = StPass;
`endif
                    end else begin
                        state_d = StFetch;
                        idx_d   = idx_q + IDX_W'(1);
                        addr_d  = idx_q + IDX_W'(1);
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_d = StFail;
                    fidx_d  = idx_q;
                    ftmo_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            StPass, StFail: state_d = state_q;
            default: state_d = StIdle;
        endcase

        led_d[3] = (state_q != StIdle);
        led_d[2] = (state_q == StFetch) || (state_q == StLoad) ||
                   (state_q == StIssue) || (state_q == StWait);
        led_d[1] = (state_q == StFail);
`ifdef VPU_SEQ_SOAK_EN
        led_d[0] = tgl_q && (state_q != StFail);
`else
        led_d[0] = (state_q == StPass);
`endif
    end

    assign rom_addr          = addr_q;
    assign vpu.vpu_req_valid = valid_q;
    assign vpu.vpu_instr     = instr_q;
    assign fail_index        = fidx_q;
    assign fail_timeout      = ftmo_q;
    assign led               = led_q;
`ifdef VPU_SEQ_SOAK_EN
    assign pass_loops        = loops_q;
`endif
endmodule

// File: tb/tb_vpu_test_sequencer.sv
// Bench for vpu_test_sequencer: a per-scenario timeline model predicts every output cycle by cycle.
module tb_vpu_test_sequencer;
    localparam int N    = 16;
    localparam int T    = 4096;
    localparam int SD   = 64;
    localparam int MAXC = 4400;
    localparam int R0   = 3;
    localparam int PH_IDLE = 0, PH_BUSY = 1, PH_PASS = 2, PH_FAIL = 3;

    logic        clk;
    logic        rst;
    logic [3:0]  rom_addr;
    logic [31:0] rom_instr;
    logic [63:0] rom_expected;
    logic [3:0]  fail_index;
    logic        fail_timeout;
    logic [3:0]  led;
`ifdef VPU_SEQ_SOAK_EN
    logic [15:0] pass_loops;
`endif

    vpu_test_sequencer_if #(.INSTR_W(32), .DATA_W(64)) vif ();

    vpu_test_sequencer #(
        .NUM_TESTS(N), .INSTR_W(32), .DATA_W(64), .TIMEOUT_CYC(T), .START_DELAY(SD)
    ) dut (
        .clk_100mhz  (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_instr   (rom_instr),
        .rom_expected(rom_expected),
        .vpu         (vif),
        .fail_index  (fail_index),
        .fail_timeout(fail_timeout),
        .led         (led)
`ifdef VPU_SEQ_SOAK_EN
        ,
        .pass_loops  (pass_loops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus timeline and expected-output timeline, indexed by scenario cycle.
    logic [31:0] rom_i [N];
    logic [63:0] rom_e [N];
    int          lat [N];
    bit          rdy [MAXC];
    bit          resv [MAXC];
    logic [63:0] resd [MAXC];
    bit          rsti [MAXC];
    bit          chk [MAXC];
    int          ph [MAXC];
    bit          ev [MAXC];
    logic [3:0]  ea [MAXC];
    logic [31:0] ei [MAXC];
    logic [3:0]  efi [MAXC];
    bit          eft [MAXC];
    bit          etg [MAXC];
    int          elp [MAXC];

    int total = 0;
    int bad   = 0;
    int sc    = -1;
    int scen  = 0;
    int corrupt_k, drop_k, rst_vec, plan_end, cut;
    bit spur;

    always @(posedge clk) begin
        rom_instr    <= rom_i[rom_addr];
        rom_expected <= rom_e[rom_addr];
    end

    function automatic logic [3:0] exp_led(input int c);
        logic [3:0] l;
        int p;
        if (rsti[c-1]) return 4'b0000;
        p = ph[c-1];
        l[3] = (p != PH_IDLE);
        l[2] = (p == PH_BUSY);
        l[1] = (p == PH_FAIL);
`ifdef VPU_SEQ_SOAK_EN
        l[0] = etg[c-1] && (p != PH_FAIL);
`else
        l[0] = (p == PH_PASS);
`endif
        return l;
    endfunction

    task automatic fill(input int c, input int p, input bit v, input logic [3:0] a,
                        input logic [31:0] ins, input logic [3:0] fi, input bit ft,
                        input bit tg, input int lp);
        if (c < MAXC) begin
            ph[c] = p; ev[c] = v; ea[c] = a; ei[c] = ins; efi[c] = fi; eft[c] = ft;
            etg[c] = tg; elp[c] = lp; chk[c] = 1'b1;
        end
    endtask

    // Walk the vectors from cycle r: each vector is FETCH, LOAD, ISSUE until ready, WAIT for result.
    task automatic plan(input int r, input bit allow_rst, output int cut_at);
        int f, h, e, k, n, passes;
        logic [3:0]  a;
        logic [31:0] ins;
        bit tg, tmo, fail;
        cut_at = -1; a = '0; ins = '0; tg = 1'b0; passes = 0; n = 0;
        for (int c = r; c < r + SD; c++) fill(c, PH_IDLE, 1'b0, '0, '0, '0, 1'b0, 1'b0, 0);
        if (spur) begin resv[r+5] = 1'b1; resd[r+5] = ~rom_e[0]; end
        f = r + SD;
        forever begin
            k = n % N;
            h = f + 2;
            while (h < MAXC - 1 && !rdy[h]) h++;
            tmo  = (k == drop_k);
            fail = tmo || (k == corrupt_k);
            e = tmo ? h + T : h + lat[k];
            if (e + 8 >= MAXC) begin plan_end = f - 1; return; end
            if (!tmo) begin
                resv[e] = 1'b1;
                resd[e] = (k == corrupt_k) ? (rom_e[k] ^ 64'd1) : rom_e[k];
            end
            if (spur) begin
                resv[h] = 1'b1; resd[h] = ~rom_e[k];
                if (f + 2 < h) begin resv[f+2] = 1'b1; resd[f+2] = ~rom_e[k]; end
            end
            if (allow_rst && k == rst_vec && n < N) begin cut_at = h + 1; rsti[cut_at] = 1'b1; end
            for (int c = f; c <= e; c++) begin
                if (cut_at >= 0 && c > cut_at) break;
                if (c == f) a = 4'(k);
                if (c == f + 2) ins = rom_i[k];
                fill(c, PH_BUSY, (c >= f + 2 && c <= h), a, ins, '0, 1'b0, tg, passes);
            end
            if (cut_at >= 0) return;
            if (fail) begin
                for (int c = e + 1; c <= e + 4; c++)
                    fill(c, PH_FAIL, 1'b0, a, ins, 4'(k), tmo, tg, passes);
                plan_end = e + 4;
                return;
            end
            if (k == N - 1) begin
`ifdef VPU_SEQ_SOAK_EN
                passes++;
                tg = ~tg;
                if (passes == 3) begin
                    fill(e + 1, PH_BUSY, 1'b0, '0, ins, '0, 1'b0, tg, passes);
                    fill(e + 2, PH_BUSY, 1'b0, '0, ins, '0, 1'b0, tg, passes);
                    plan_end = e + 2;
                    return;
                end
`else
                for (int c = e + 1; c <= e + 4; c++)
                    fill(c, PH_PASS, 1'b0, a, ins, '0, 1'b0, tg, passes);
                plan_end = e + 4;
                return;
`endif
            end
            f = e + 1;
            n++;
        end
    endtask

    task automatic setup(input bit rand_rdy, input bit rand_lat);
        logic [31:0] tmp;
        scen++;
        sc = -1;
        for (int c = 0; c < MAXC; c++) begin
            rdy[c] = rand_rdy ? ($urandom_range(0, 9) < 6) : 1'b1;
            resv[c] = 1'b0; resd[c] = '0; rsti[c] = (c < R0); chk[c] = 1'b0;
            ph[c] = PH_IDLE; ev[c] = 1'b0; ea[c] = '0; ei[c] = '0; efi[c] = '0;
            eft[c] = 1'b0; etg[c] = 1'b0; elp[c] = 0;
        end
        for (int k = 0; k < N; k++) begin
            tmp = $urandom();
            rom_i[k] = {tmp[31:4], 4'(k)};
            rom_e[k] = {$urandom(), $urandom()};
            lat[k] = rand_lat ? int'($urandom_range(1, 6)) : 3;
        end
        corrupt_k = -1; drop_k = -1; rst_vec = -1; spur = 1'b0;
    endtask

    task automatic build();
        int dummy;
        plan(R0, 1'b1, cut);
        if (cut >= 0) plan(cut + 1, 1'b0, dummy);
    endtask

    task automatic step_to(input int t);
        while (sc < t && sc < MAXC - 1) begin
            @(posedge clk);
            #1;
            sc = sc + 1;
            rst = rsti[sc];
            vif.vpu_req_ready = rdy[sc];
            vif.vpu_res_valid = resv[sc];
            if (resv[sc]) vif.vpu_res_data = resd[sc];
            else vif.vpu_res_data = {$urandom(), $urandom()};
        end
    endtask

    task automatic finish_scen();
        step_to(plan_end);
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s scen%0d cyc%0d: got %0h, want %0h", name, scen, sc, got, want);
        end
    endtask

    task automatic check_pass_end();
`ifdef VPU_SEQ_SOAK_EN
        lit("pass_loops", 64'(pass_loops), 64'd3);
`else
        lit("pass_led", 64'(led), 64'b1001);
`endif
    endtask

    always @(negedge clk) begin
        if (sc >= 1 && sc < MAXC && chk[sc]) begin
            logic [3:0] el;
            el = exp_led(sc);
            total++;
            if (rom_addr !== ea[sc] || vif.vpu_req_valid !== ev[sc] || vif.vpu_instr !== ei[sc] ||
                fail_index !== efi[sc] || fail_timeout !== eft[sc] || led !== el) begin
                bad++;
                $display("FAIL outputs scen%0d cyc%0d: got addr=%0d valid=%0b instr=%h fidx=%0d ftmo=%0b led=%b; want addr=%0d valid=%0b instr=%h fidx=%0d ftmo=%0b led=%b",
                         scen, sc, rom_addr, vif.vpu_req_valid, vif.vpu_instr, fail_index,
                         fail_timeout, led, ea[sc], ev[sc], ei[sc], efi[sc], eft[sc], el);
            end
`ifdef VPU_SEQ_SOAK_EN
            total++;
            if (pass_loops !== 16'(elp[sc])) begin
                bad++;
                $display("FAIL pass_loops scen%0d cyc%0d: got %0d, want %0d", scen, sc, pass_loops, elp[sc]);
            end
`endif
        end
    end

    initial begin
        rst = 1'b1;
        vif.vpu_req_ready = 1'b0;
        vif.vpu_res_valid = 1'b0;
        vif.vpu_res_data  = '0;

        // Clean run, ready always high, result 3 cycles after accept.
        setup(1'b0, 1'b0);
        build();
        step_to(R0);
        lit("reset_led", 64'(led), 64'd0);
        lit("reset_valid", 64'(vif.vpu_req_valid), 64'd0);
        lit("reset_instr", 64'(vif.vpu_instr), 64'd0);
`ifndef VPU_SEQ_SOAK_EN
        step_to(R0 + 160);
        lit("last_busy_led", 64'(led), 64'b1100);
        step_to(R0 + 161);
        lit("first_pass_led", 64'(led), 64'b1001);
`endif
        finish_scen();
        check_pass_end();

        // Bit 0 of vector 5's result flipped.
        setup(1'b0, 1'b0);
        corrupt_k = 5;
        build();
        finish_scen();
        lit("mm_led", 64'(led), 64'b1010);
        lit("mm_index", 64'(fail_index), 64'd5);
        lit("mm_timeout", 64'(fail_timeout), 64'd0);

        // Vector 2 never answered.
        setup(1'b0, 1'b0);
        drop_k = 2;
        build();
        step_to(R0 + 4175);
        lit("tmo_before_led", 64'(led), 64'b1100);
        step_to(R0 + 4176);
        lit("tmo_led", 64'(led), 64'b1010);
        lit("tmo_index", 64'(fail_index), 64'd2);
        lit("tmo_flag", 64'(fail_timeout), 64'd1);
        finish_scen();

        // Ready held low for 20 cycles on vector 0.
        setup(1'b0, 1'b0);
        for (int c = R0 + SD + 2; c < R0 + SD + 22; c++) rdy[c] = 1'b0;
        build();
        step_to(R0 + SD + 21);
        lit("stall_valid", 64'(vif.vpu_req_valid), 64'd1);
        lit("stall_instr", 64'(vif.vpu_instr), 64'(rom_i[0]));
        step_to(R0 + SD + 23);
        lit("stall_valid_drop", 64'(vif.vpu_req_valid), 64'd0);
        finish_scen();
        check_pass_end();

        // Spurious wrong results in IDLE and ISSUE, random ready and latency.
        setup(1'b1, 1'b1);
        spur = 1'b1;
        build();
        finish_scen();
        check_pass_end();

        // One-cycle reset during vector 9's WAIT; its late result must be ignored.
        setup(1'b0, 1'b0);
        rst_vec = 9;
        build();
        step_to(cut + 1);
        lit("rst_led", 64'(led), 64'd0);
        lit("rst_valid", 64'(vif.vpu_req_valid), 64'd0);
        finish_scen();
        check_pass_end();

        // Random runs: one with a random corrupted vector, one clean.
        setup(1'b1, 1'b1);
        corrupt_k = int'($urandom_range(0, N - 1));
        build();
        finish_scen();
        lit("rand_mm_led", 64'(led), 64'b1010);
        lit("rand_mm_index", 64'(fail_index), 64'(corrupt_k));

        setup(1'b1, 1'b1);
        build();
        finish_scen();
        check_pass_end();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
